seq_pattern_tx: RTL and testbench

Serial pattern transmitter. It is the source end of the serial bit stream that the sequence-detector blocks consume.
- Accepts a pattern word, repeat count and inter-frame gap over a valid/ready handshake.
- Serialises the pattern MSB-first, one bit per clock, on x, with x_valid qualifying each bit.
- Drives detector benches and on-chip self-test, for example 1010 frames into a Mealy 1010 detector.

---
 rtl/seq_pattern_tx.sv | 142 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a pattern MSB-first, repeated a requested
// number of times with an optional idle gap between copies.
module seq_pattern_tx #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAT_W-1:0] in_pattern,
  input  logic [CNT_W-1:0] in_repeat,
  input  logic [CNT_W-1:0] in_gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               done_q, done_d;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign done     = done_q;

  // Outputs are derived from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pat_d = in_pattern;
          gap_d = in_gap;
          rem_d = in_repeat;
          idx_d = IDX_MAX;
          if (in_repeat != {CNT_W{1'b0}}) begin
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (idx_q == {IDX_W{1'b0}}) begin
          rem_d = rem_q - CNT_W'(1);
          idx_d = IDX_MAX;
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
          end else if (gap_q == {CNT_W{1'b0}}) begin
            state_d = SHIFT;
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q <= CNT_W'(1)) begin
          state_d = SHIFT;
          gcnt_d  = {CNT_W{1'b0}};
          idx_d   = IDX_MAX;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    x_valid_d = (state_d == SHIFT);
    if (x_valid_d) begin
      x_d = pat_d[idx_d];
    end else begin
      x_d = IDLE_BIT;
    end
    // The last bit of the last copy carries done alongside it.
    if (x_valid_d && (idx_d == {IDX_W{1'b0}}) && (rem_d == CNT_W'(1))) begin
      done_d = 1'b1;
    end else begin
      done_d = done_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= {PAT_W{1'b0}};
      gap_q     <= {CNT_W{1'b0}};
      rem_q     <= {CNT_W{1'b0}};
      gcnt_q    <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      gap_q     <= gap_d;
      rem_q     <= rem_d;
      gcnt_q    <= gcnt_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios plus random
// commands, compared against a per-cycle stream model built from the frame rules.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_pattern;
  logic [3:0] in_repeat;
  logic [3:0] in_gap;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // expected {x, x_valid, done, busy} for each cycle after acceptance
  logic [3:0] exp_q[$];

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pattern(in_pattern),
    .in_repeat (in_repeat),
    .in_gap    (in_gap),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Frame model: repeat copies of the pattern MSB-first, gap idle cycles between copies.
  task automatic build_exp(input logic [3:0] p, input int r, input int g);
    exp_q.delete();
    if (r == 0) begin
      exp_q.push_back(4'b0010);
    end else begin
      for (int c = 0; c < r; c++) begin
        for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b0, 1'b1});
        if (c < r - 1)
          for (int j = 0; j < g; j++) exp_q.push_back(4'b0001);
      end
      exp_q[exp_q.size()-1][1] = 1'b1;
    end
  endtask

  // Present a command from a negedge; it is accepted at the following posedge.
  task automatic issue_cmd(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
    in_valid   = 1'b1;
    in_pattern = p;
    in_repeat  = r;
    in_gap     = g;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_pattern = 4'($urandom);
    in_repeat  = 4'($urandom);
    in_gap     = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_pattern = 4'h0; in_repeat = 4'h0; in_gap = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x, x_valid, done, busy, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset got=%b exp=00001", {x, x_valid, done, busy, in_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    build_exp(4'b1010, 1, 0);
    issue_cmd(4'b1010, 4'd1, 4'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL single cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({in_ready, x_valid, done} !== 3'b100) begin
      failures++;
      $display("FAIL single_after got=%b exp=100", {in_ready, x_valid, done});
    end
  endtask

  task automatic test_copies();
    build_exp(4'b1010, 3, 0);
    issue_cmd(4'b1010, 4'd3, 4'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL copies cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_gap();
    build_exp(4'b1100, 2, 2);
    issue_cmd(4'b1100, 4'd2, 4'd2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL gap cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_repeat();
    issue_cmd(4'b1111, 4'd0, 4'd3);
    @(negedge clk);
    checks++;
    if ({x, x_valid, done, busy, in_ready} !== 5'b00101) begin
      failures++;
      $display("FAIL zero_rep got=%b exp=00101", {x, x_valid, done, busy, in_ready});
    end
    @(negedge clk);
    checks++;
    if ({x_valid, done, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL zero_rep_after got=%b exp=001", {x_valid, done, in_ready});
    end
  endtask

  task automatic test_ignored();
    build_exp(4'b1001, 2, 1);
    issue_cmd(4'b1001, 4'd2, 4'd1);
    in_valid = 1'b1; in_pattern = 4'b1111; in_repeat = 4'd5; in_gap = 4'd0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL ignored cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
      if (i == exp_q.size() - 1) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({busy, x_valid} !== 2'b00) begin
      failures++;
      $display("FAIL ignored_after got=%b exp=00", {busy, x_valid});
    end
  endtask

  task automatic test_reset_mid();
    issue_cmd(4'b1010, 4'd2, 4'd0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({x, x_valid, busy} !== 3'b011) begin
      failures++;
      $display("FAIL rst_mid_bit2 got=%b exp=011", {x, x_valid, busy});
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({x, x_valid, done, busy, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=00001", {x, x_valid, done, busy, in_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({done, x_valid, busy} !== 3'b000) begin
        failures++;
        $display("FAIL rst_mid_quiet cyc%0d got=%b exp=000", i, {done, x_valid, busy});
      end
    end
  endtask

  task automatic test_back_to_back();
    build_exp(4'b0110, 1, 0);
    issue_cmd(4'b0110, 4'd1, 4'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_a cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({in_ready, x_valid, x} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=100", {in_ready, x_valid, x});
    end
    build_exp(4'b1011, 2, 0);
    issue_cmd(4'b1011, 4'd2, 4'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, busy} !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_b cyc%0d got=%b exp=%b", i + 1, {x, x_valid, done, busy}, exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] p, r, g;
    int idle;
    for (int n = 0; n < 25; n++) begin
      p = 4'($urandom);
      r = 4'($urandom_range(0, 3));
      g = 4'($urandom_range(0, 3));
      build_exp(p, int'(r), int'(g));
      issue_cmd(p, r, g);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        checks++;
        if ({x, x_valid, done, busy} !== exp_q[i]) begin
          failures++;
          $display("FAIL rand n%0d p=%b r=%0d g=%0d cyc%0d got=%b exp=%b",
                   n, p, r, g, i + 1, {x, x_valid, done, busy}, exp_q[i]);
        end
      end
      idle = $urandom_range(1, 3);
      repeat (idle) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_copies();
    test_gap();
    test_zero_repeat();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
